// File: rtl/ksa_param.sv
// RC4 key-scheduling engine with runtime key length, optional identity fill and
// configurable read latency towards a single-port 256-byte S memory.
module ksa_param #(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [5:0]             keylen,
    input  logic                   fill,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    typedef enum logic [2:0] {
        IDLE, FILL, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [4:0]             r_k;
    logic [4:0]             r_klast;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [1:0]             r_wait;

    logic [7:0]             w_keybyte;
    logic [7:0]             w_jnext;
    logic [4:0]             w_klast;
    logic                   w_wait_done;

    always_comb begin
        w_keybyte = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (r_k == 5'(n)) begin
                w_keybyte = r_key[8*(KEY_BYTES-1-n) +: 8];
            end
        end
    end

    // A zero or oversized key length falls back to the full key width.
    always_comb begin
        if (keylen == 6'd0 || keylen > 6'(KEY_BYTES)) begin
            w_klast = 5'(KEY_BYTES - 1);
        end else begin
            w_klast = 5'(keylen - 6'd1);
        end
    end

    assign w_jnext     = r_j + r_si + w_keybyte;
    assign w_wait_done = (r_wait == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en) w_next = fill ? FILL : READ_I;
            FILL:    if (r_i == 8'hFF) w_next = READ_I;
            READ_I:  w_next = WAIT_I;
            WAIT_I:  if (w_wait_done) w_next = READ_J;
            READ_J:  w_next = WAIT_J;
            WAIT_J:  if (w_wait_done) w_next = WRITE_I;
            WRITE_I: w_next = WRITE_J;
            WRITE_J: w_next = (r_i == 8'hFF) ? IDLE : READ_I;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i     <= 8'h00;
            r_j     <= 8'h00;
            r_k     <= 5'd0;
            r_klast <= 5'd0;
            r_key   <= '0;
            r_si    <= 8'h00;
            r_sj    <= 8'h00;
            r_wait  <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_key   <= key;
                        r_klast <= w_klast;
                        r_i     <= 8'h00;
                        r_j     <= 8'h00;
                        r_k     <= 5'd0;
                    end
                end
                FILL: begin
                    r_i <= r_i + 8'd1;
                end
                READ_I: begin
                    r_wait <= 2'd0;
                end
                WAIT_I: begin
                    if (w_wait_done) r_si <= rddata;
                    else             r_wait <= r_wait + 2'd1;
                end
                READ_J: begin
                    r_j    <= w_jnext;
                    r_wait <= 2'd0;
                end
                WAIT_J: begin
                    if (w_wait_done) r_sj <= rddata;
                    else             r_wait <= r_wait + 2'd1;
                end
                WRITE_J: begin
                    r_k <= (r_k == r_klast) ? 5'd0 : r_k + 5'd1;
                    if (r_i != 8'hFF) r_i <= r_i + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // When i==j the WRITE_J store of si lands last, which is the correct swap result.
    always_comb begin
        rdy    = 1'b0;
        addr   = 8'h00;
        wrdata = 8'h00;
        wren   = 1'b0;
        case (r_state)
            IDLE:    rdy = 1'b1;
            FILL: begin
                addr   = r_i;
                wrdata = r_i;
                wren   = 1'b1;
            end
            READ_I:  addr = r_i;
            WAIT_I:  addr = r_i;
            READ_J:  addr = w_jnext;
            WAIT_J:  addr = r_j;
            WRITE_I: begin
                addr   = r_i;
                wrdata = r_sj;
                wren   = 1'b1;
            end
            WRITE_J: begin
                addr   = r_j;
                wrdata = r_si;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
